tpu_result_checker: RTL
=======================

# tpu_result_checker

Synthesizable result checker that compares the TPU output global buffer against a golden buffer one row at a time and reports the mismatch count, the first failing location and a done flag. It sits beside `top` in the verification/bring-up wrapper and replaces per-byte procedural comparison with a parametrised, pipelined hardware scoreboard. The same block is usable on FPGA for on-board self-test.

## Interface
- `DATA_SIZE`, 8, width of one lane (matrix element)
- `LANES`, 4, lanes per buffer word; word width = `LANES*DATA_SIZE`
- `DEPTH`, 4, maximum rows checked
- `ADDR_W`, `$clog2(DEPTH)`, row address width (minimum 1)
- `CNT_W`, `$clog2(DEPTH*LANES+1)`, error counter width

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a check; sampled only in IDLE or DONE
- `num_rows`  in  ADDR_W+1  rows to check; sampled with `start`
- `lane_swap`  in  1  1: golden lane j is compared to output lane LANES-1-j; sampled with `start`
- `rd_addr`  out  ADDR_W  shared read address to both buffers
- `rd_en`  out  1  read strobe
- `gold_rdata`  in  LANES*DATA_SIZE  golden word, valid one cycle after `rd_en`
- `out_rdata`  in  LANES*DATA_SIZE  output-buffer word, valid one cycle after `rd_en`
- `busy`  out  1  check in progress
- `done`  out  1  check complete; level, held until next `start`
- `err_cnt`  out  CNT_W  mismatching lanes, saturating
- `first_err_addr`  out  ADDR_W  row of first mismatch
- `first_err_lane`  out  `$clog2(LANES)`  lane of first mismatch (lowest lane index within the row)
- `first_err_vld`  out  1  first-error fields valid

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE/DONE + `start`: latch `min(num_rows, DEPTH)` and `lane_swap`, clear `err_cnt`, `first_err_*`, `done`; go to READ, or directly to DONE if the latched row count is 0.
- READ: `rd_en`=1, `rd_addr` increments 0..N-1, one row per cycle; after issuing N-1, go to DRAIN.
- DRAIN: one cycle for the final compare, then DONE.
- Compare stage (registered `rd_en` delayed by 1 = `cmp_vld`): per lane, compute mismatch bit; row mismatch count = popcount of mismatch vector; `err_cnt` += count, saturating at `2^CNT_W-1`.
- `start` while `busy`: ignored. `lane_swap`/`num_rows` changes after `start`: ignored.
- Reset (any state, including mid-check): all outputs 0, FSM to IDLE; no partial result retained.

## Timing
- Reset values: `rd_addr`=0, `rd_en`=0, `busy`=0, `done`=0, `err_cnt`=0, `first_err_addr`=0, `first_err_lane`=0, `first_err_vld`=0.
- Cycle 0: `start` sampled. Cycles 1..N: `rd_en`=1, `rd_addr`=k at cycle k+1. Compare of row k at cycle k+2.
- `done` rises at cycle N+2; `busy` high cycles 1..N+1. N=0: `done` at cycle 1, `busy` never rises.
- `err_cnt` final when `done`=1; intermediate values are visible but not defined as a contract.
- Back-to-back: `start` in the same cycle `done` is high restarts; `done` drops the next cycle.

## Configuration
- `TPU_CHECKER_FIRST_ERR_EN` defined: first-mismatch capture logic is built; the first row with a nonzero mismatch vector loads `first_err_addr`/`first_err_lane` and sets `first_err_vld`; later mismatches do not overwrite.
- Undefined: capture logic is omitted; `first_err_addr`, `first_err_lane`, `first_err_vld` are tied to 0; `err_cnt` is unaffected.

## Structure
- Shared package `tpu_pkg`: FSM state enum, `DATA_SIZE` default, `lane_rev` function (lane index reversal).
- One sub-module: `lane_cmp` (combinational compare of one word pair, with swap, producing mismatch vector, popcount and lowest-set index); FSM, counters and capture are in `tpu_result_checker`.

## Test plan
- Defaults, N=4, golden == output, swap=0 -> `done` at cycle 6, `err_cnt`=0, `first_err_vld`=0.
- N=4, output row 2 lane 1 = 0x5A vs golden 0x3C -> `err_cnt`=1, `first_err_addr`=2, `first_err_lane`=1 (macro on); all three 0 with macro off.
- swap=1, output words byte-reversed relative to golden (golden 0x01020304, output 0x04030201) -> `err_cnt`=0; same data with swap=0 -> `err_cnt`=16.
- `num_rows`=0 -> `done` at cycle 1, `rd_en` never asserts; `num_rows`=7 with DEPTH=4 -> exactly 4 reads.
- Assert `rst` low at cycle 3 of an N=4 check with errors -> all outputs 0 immediately; a new `start` reruns and gives the correct count.
- `start` pulsed at cycle 2 while busy with `num_rows`=1 -> ignored; the run completes with N=4 and `done` at cycle 6.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU result checker: FSM state encoding,
// default lane width and the lane-index reversal helper used for swapped compares.
package tpu_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chkState_e;

    // Mirror a lane index inside a word of 'lanes' lanes (lane 0 <-> lane lanes-1).
    function automatic int lane_rev(input int lane, input int lanes);
        return lanes - 1 - lane;
    endfunction

endpackage

// File: rtl/tpu_result_checker_lane_cmp.sv
// lane_cmp: purely combinational compare of one golden word against one
// output-buffer word. Golden lane j is compared with output lane j, or with
// output lane LANES-1-j when swap_i is set. Produces the mismatch popcount and,
// when TPU_CHECKER_FIRST_ERR_EN is defined, an any-mismatch flag plus the
// lowest mismatching golden lane index.
module lane_cmp
    import tpu_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int LANES     = 4,
    parameter int CW        = $clog2(LANES + 1),
    parameter int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES*DATA_SIZE-1:0] gold_i,
    input  logic [LANES*DATA_SIZE-1:0] out_i,
    input  logic                       swap_i,
    output logic [CW-1:0]              mis_cnt_o
`ifdef TPU_CHECKER_FIRST_ERR_EN
    ,
    output logic                       any_o,
    output logic [LW-1:0]              low_idx_o
`endif
);

    logic [LANES-1:0] misVec;

    // One mismatch bit per golden lane, picking the partner output lane by swap mode.
    always_comb begin
        misVec = '0;
        for (int j = 0; j < LANES; j++) begin
            misVec[j] = gold_i[j*DATA_SIZE +: DATA_SIZE] !=
                        out_i[(swap_i ? lane_rev(j, LANES) : j)*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Count how many lanes of this row disagree.
    always_comb begin
        mis_cnt_o = '0;
        for (int j = 0; j < LANES; j++) begin
            mis_cnt_o = mis_cnt_o + CW'(misVec[j]);
        end
    end

`ifdef TPU_CHECKER_FIRST_ERR_EN
    // Scan from the top so the lowest mismatching lane wins.
    always_comb begin
        low_idx_o = '0;
        any_o     = |misVec;
        for (int j = LANES - 1; j >= 0; j--) begin
            if (misVec[j]) begin
                low_idx_o = LW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/tpu_result_checker.sv
// tpu_result_checker: walks rows 0..N-1 of the golden and output buffers
// through one shared read port, compares each row one cycle after the read and
// accumulates a saturating mismatch count. First-mismatch capture
// (first_err_addr/lane/vld) is only built when TPU_CHECKER_FIRST_ERR_EN is
// defined; otherwise those outputs are tied to 0.
module tpu_result_checker
    import tpu_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int LANES     = 4,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W     = $clog2(DEPTH*LANES + 1),
    parameter int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W:0]            num_rows,
    input  logic                       lane_swap,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_en,
    input  logic [LANES*DATA_SIZE-1:0] gold_rdata,
    input  logic [LANES*DATA_SIZE-1:0] out_rdata,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [ADDR_W-1:0]          first_err_addr,
    output logic [LW-1:0]              first_err_lane,
    output logic                       first_err_vld
);

    localparam int PW = $clog2(LANES + 1);
    localparam logic [ADDR_W:0]  DEPTH_ROWS = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    chkState_e         state_q, state_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic [ADDR_W:0]   rows_q, rows_d;
    logic              swap_q, swap_d;
    logic              cmpVld_q;
    logic [CNT_W-1:0]  errCnt_q, errCnt_d;
    logic [CNT_W:0]    cntSum;
    logic [PW-1:0]     rowMisCnt;
    logic              clearResults;

    // Next-state logic: accept start only when idle or finished, then walk the rows.
    always_comb begin
        state_d      = state_q;
        rdAddr_d     = rdAddr_q;
        rows_d       = rows_q;
        swap_d       = swap_q;
        clearResults = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rows_d       = (num_rows > DEPTH_ROWS) ? DEPTH_ROWS : num_rows;
                    swap_d       = lane_swap;
                    rdAddr_d     = '0;
                    clearResults = 1'b1;
                    state_d      = (rows_d == '0) ? DONE : READ;
                end
            end
            READ: begin
                if ({1'b0, rdAddr_q} == rows_q - 1'b1) begin
                    state_d = DRAIN;
                end else begin
                    rdAddr_d = rdAddr_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address and latched run parameters; reset abandons any partial check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rdAddr_q <= '0;
            rows_q   <= '0;
            swap_q   <= 1'b0;
            cmpVld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdAddr_q <= rdAddr_d;
            rows_q   <= rows_d;
            swap_q   <= swap_d;
            cmpVld_q <= rd_en;
        end
    end

    assign rd_en   = (state_q == READ);
    assign rd_addr = rdAddr_q;
    assign busy    = (state_q == READ) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

`ifdef TPU_CHECKER_FIRST_ERR_EN
    logic              rowAnyMis;
    logic [LW-1:0]     rowLowLane;

    lane_cmp #(
        .DATA_SIZE (DATA_SIZE),
        .LANES     (LANES),
        .CW        (PW),
        .LW        (LW)
    ) u_lane_cmp (
        .gold_i    (gold_rdata),
        .out_i     (out_rdata),
        .swap_i    (swap_q),
        .mis_cnt_o (rowMisCnt),
        .any_o     (rowAnyMis),
        .low_idx_o (rowLowLane)
    );
`else
    lane_cmp #(
        .DATA_SIZE (DATA_SIZE),
        .LANES     (LANES),
        .CW        (PW),
        .LW        (LW)
    ) u_lane_cmp (
        .gold_i    (gold_rdata),
        .out_i     (out_rdata),
        .swap_i    (swap_q),
        .mis_cnt_o (rowMisCnt)
    );
`endif

    // Accumulate row mismatches into the error counter, clamping at all-ones.
    always_comb begin
        cntSum   = {1'b0, errCnt_q} + (CNT_W+1)'(rowMisCnt);
        errCnt_d = errCnt_q;
        if (clearResults) begin
            errCnt_d = '0;
        end else if (cmpVld_q) begin
            errCnt_d = (cntSum > {1'b0, CNT_MAX}) ? CNT_MAX : cntSum[CNT_W-1:0];
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;

`ifdef TPU_CHECKER_FIRST_ERR_EN
    logic [ADDR_W-1:0] cmpAddr_q;
    logic [ADDR_W-1:0] firstAddr_q, firstAddr_d;
    logic [LW-1:0]     firstLane_q, firstLane_d;
    logic              firstVld_q, firstVld_d;

    // Capture only the first mismatching row of a run; later rows never overwrite it.
    always_comb begin
        firstAddr_d = firstAddr_q;
        firstLane_d = firstLane_q;
        firstVld_d  = firstVld_q;
        if (clearResults) begin
            firstAddr_d = '0;
            firstLane_d = '0;
            firstVld_d  = 1'b0;
        end else if (cmpVld_q && rowAnyMis && !firstVld_q) begin
            firstAddr_d = cmpAddr_q;
            firstLane_d = rowLowLane;
            firstVld_d  = 1'b1;
        end
    end

    // Row address tracking the compare stage, plus the first-error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmpAddr_q   <= '0;
            firstAddr_q <= '0;
            firstLane_q <= '0;
            firstVld_q  <= 1'b0;
        end else begin
            cmpAddr_q   <= rdAddr_q;
            firstAddr_q <= firstAddr_d;
            firstLane_q <= firstLane_d;
            firstVld_q  <= firstVld_d;
        end
    end

    assign first_err_addr = firstAddr_q;
    assign first_err_lane = firstLane_q;
    assign first_err_vld  = firstVld_q;
`else
    assign first_err_addr = '0;
    assign first_err_lane = '0;
    assign first_err_vld  = 1'b0;
`endif

endmodule
